// File: rtl/rom_loader_if.sv
// ioctl download port and SDRAM write port of the ROM loader.
// The slave modport is the loader; the master side is the host/SDRAM glue.
interface rom_loader_if #(
   parameter int unsigned ADDR_W = 23,
   parameter int unsigned BANK_W = 2
);
   logic              dl;
   logic              dl_wr;
   logic [24:0]       dl_addr;
   logic [7:0]        dl_data;
   logic [7:0]        dl_index;
   logic [15:0]       dl_ext;
   logic              dl_wait;
   logic              wr;
   logic [ADDR_W-1:0] wr_addr;
   logic [BANK_W-1:0] wr_bank;
   logic [7:0]        wr_data;

   modport master (
      output dl, dl_wr, dl_addr, dl_data, dl_index, dl_ext,
      input  dl_wait, wr, wr_addr, wr_bank, wr_data
   );

   modport slave (
      input  dl, dl_wr, dl_addr, dl_data, dl_index, dl_ext,
      output dl_wait, wr, wr_addr, wr_bank, wr_data
   );
endinterface

// File: rtl/rom_loader.sv
// Streams downloaded ROM images into SDRAM in ce_ref slots, replicating
// expansion ROMs across banks, and keeps a map of populated upper-ROM pages.
module rom_loader #(
   parameter int unsigned ADDR_W    = 23,
   parameter int unsigned BANKS     = 2,
   parameter int unsigned BANK_W    = 2,
   parameter int unsigned MAP_PAGES = 256
) (
   input  logic         clk_sys,
   input  logic         reset_n,
   input  logic         ce_ref,
   rom_loader_if.slave  bus,
   input  logic [7:0]   map_addr,
   output logic         map_hit,
   output logic         ext_bad,
   output logic         busy
);
   localparam int unsigned BOOT_CHUNKS = 4 * BANKS;
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BANKS - 1);

   typedef enum logic [1:0] {IDLE, ARM, WRITE} state_t;

   state_t               state, state_nx;
   logic                 dl_q;
   logic                 pend, pend_boot;
   logic [15:0]          pend_ext;
   logic [8:0]           page;
   logic                 combo;
   logic [ADDR_W-1:0]    addr;
   logic [BANK_W-1:0]    bank;
   logic [7:0]           data;
   logic                 rep;
   logic                 wr_q;
   logic [MAP_PAGES-1:0] map;

   logic                 dl_rise, apply, upd_boot;
   logic [15:0]          upd_ext;
   logic [8:0]           par_page, page_eff, bp;
   logic                 par_combo, par_bad, combo_eff;
   logic                 go, rep_nx;
   logic [ADDR_W-1:0]    addr_nx;
   logic [BANK_W-1:0]    bank_nx;
   logic [10:0]          chunk;
   logic                 accept, adv, fin;

   function automatic logic is_hex(input logic [7:0] c);
      return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] c);
      return (c <= 8'h39) ? c[3:0] : 4'(c[3:0] + 4'd9);
   endfunction

   function automatic logic [8:0] boot_page(input logic [1:0] slot);
      case (slot)
         2'd0:    return 9'h000;
         2'd1:    return 9'h100;
         2'd2:    return 9'h107;
         default: return 9'h1FF;
      endcase
   endfunction

   // Extension parse; a rise seen while busy is held until the FSM is idle.
   always_comb begin
      dl_rise   = bus.dl & ~dl_q;
      upd_ext   = dl_rise ? bus.dl_ext : pend_ext;
      upd_boot  = dl_rise ? (bus.dl_index == 8'd0) : pend_boot;
      apply     = (state == IDLE) && (dl_rise || pend);
      par_page  = page;
      par_combo = combo;
      par_bad   = ext_bad;
      if (!upd_boot) begin
         if (is_hex(upd_ext[15:8]) && is_hex(upd_ext[7:0])) begin
            par_page = {1'b1, hex_val(upd_ext[15:8]), hex_val(upd_ext[7:0])};
            par_bad  = 1'b0;
         end else if (upd_ext == 16'h5A5A) begin
            par_page = 9'h000;
            par_bad  = 1'b0;
         end else if (upd_ext == 16'h5A30) begin
            par_page  = 9'h000;
            par_combo = 1'b1;
            par_bad   = 1'b0;
         end else begin
            par_page = 9'h1EE;
            par_bad  = 1'b1;
         end
      end
      page_eff  = apply ? par_page : page;
      combo_eff = apply ? par_combo : combo;
   end

   // Address/bank decode for a byte offered in IDLE.
   always_comb begin
      go      = 1'b0;
      rep_nx  = 1'b0;
      addr_nx = '0;
      bank_nx = '0;
      chunk   = bus.dl_addr[24:14];
      bp      = boot_page(chunk[1:0]);
      if (bus.dl_index != 8'd0) begin
         go                  = 1'b1;
         addr_nx[ADDR_W-1]   = page_eff[8];
         addr_nx[21:14]      = page_eff[7:0] + bus.dl_addr[21:14];
         rep_nx              = (bus.dl_index[7:6] == 2'b01) || (bus.dl_index[5:0] != 6'd0);
      end else if (32'(chunk) < BOOT_CHUNKS) begin
         go                  = 1'b1;
         addr_nx[ADDR_W-1]   = bp[8];
         addr_nx[21:14]      = bp[7:0];
         bank_nx             = BANK_W'(chunk[10:2]);
      end
      addr_nx[13:0] = bus.dl_addr[13:0];
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      adv      = 1'b0;
      fin      = 1'b0;
      unique case (state)
         IDLE: if (bus.dl_wr && go) begin
            accept   = 1'b1;
            state_nx = ARM;
         end
         ARM: if (ce_ref) state_nx = WRITE;
         WRITE: if (ce_ref) begin
            if (!rep || (bank == LAST_BANK)) begin
               fin      = 1'b1;
               state_nx = IDLE;
            end else begin
               adv      = 1'b1;
               state_nx = ARM;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dl_q      <= 1'b0;
         pend      <= 1'b0;
         pend_boot <= 1'b0;
         pend_ext  <= '0;
         page      <= '0;
         combo     <= 1'b0;
         ext_bad   <= 1'b0;
         addr      <= '0;
         bank      <= '0;
         data      <= '0;
         rep       <= 1'b0;
         wr_q      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         dl_q <= bus.dl;
         if (apply) begin
            page    <= par_page;
            combo   <= par_combo;
            ext_bad <= par_bad;
            pend    <= 1'b0;
         end else if (dl_rise) begin
            pend      <= 1'b1;
            pend_ext  <= bus.dl_ext;
            pend_boot <= (bus.dl_index == 8'd0);
         end
         if (accept) begin
            addr <= addr_nx;
            bank <= bank_nx;
            data <= bus.dl_data;
            rep  <= rep_nx;
         end
         if (adv) bank <= bank + BANK_W'(1);
         // Combo image: after the first 16 KB the rest lands from page 0x1FF on.
         if (fin && combo && (addr[13:0] == 14'h3FFF)) begin
            combo <= 1'b0;
            page  <= 9'h1FF;
         end
         wr_q <= (state_nx == WRITE);
         busy <= (state_nx != IDLE);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         map     <= '0;
         map_hit <= 1'b0;
      end else begin
         if (fin && addr[ADDR_W-1]) map[addr[21:14]] <= 1'b1;
         map_hit <= map[map_addr];
      end
   end

   assign bus.dl_wait = busy;
   assign bus.wr      = wr_q;
   assign bus.wr_addr = addr;
   assign bus.wr_bank = bank;
   assign bus.wr_data = data;
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Streams host-downloaded ROM images into SDRAM and maintains the page map that marks which upper-ROM pages are populated.
- Generalises the CPC boot/expansion loader to BANKS model banks, with per-byte bank replication and a malformed-extension flag.
- Sits between hps_io ioctl and the sdram write port; writes are issued in ce_ref slots while the system is held in reset.

Parameters:
ADDR_W, 23, SDRAM byte address width; bit ADDR_W-1 selects the ROM region.
BANKS, 2, number of model banks, 1..4.
BANK_W, 2, width of wr_bank; must satisfy 2^BANK_W >= BANKS.
MAP_PAGES, 256, number of 16 KB ROM pages tracked in the map.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce_ref  in  1  SDRAM write slot strobe
dl  in  1  download active
dl_wr  in  1  download byte strobe
dl_addr  in  25  byte offset within the file
dl_data  in  8  byte data
dl_index  in  8  file index; 0 = boot image
dl_ext  in  16  2-char file extension, ASCII, upper char in [15:8]
dl_wait  out  1  host stall
wr  out  1  SDRAM write request
wr_addr  out  ADDR_W  SDRAM byte address
wr_bank  out  BANK_W  SDRAM bank
wr_data  out  8  byte to write
map_addr  in  8  map query page
map_hit  out  1  page loaded; registered, 1-cycle latency
ext_bad  out  1  last extension was malformed
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): page=0, combo=0, every map bit 0, state IDLE. All outputs 0.
- dl rising edge (dl_index!=0): parse dl_ext.
  - Both chars hex 0-9/A-F: page={1, hi nibble, lo nibble}, ext_bad=0.
  - "ZZ": page=0. "Z0": page=0, combo=1.
  - Anything else: page=0x1EE, ext_bad=1.
- dl rising edge (dl_index==0): no parsing; ext_bad is unchanged.
- Byte accept (dl_wr in IDLE): latch dl_data, set dl_wait=1.
  - dl_addr[13:0] always goes to addr[13:0].
  - Expansion file (index!=0): addr[ADDR_W-1:14]={page[8], page[7:0]+dl_addr[21:14]}; 8-bit add wraps mod 256. Replicate=1 when dl_index[7:6]==1 or dl_index[5:0]!=0.
  - Boot file (index==0): chunk k=dl_addr[24:14], slot k%4 maps to pages 0x000, 0x100, 0x107, 0x1FF; bank=k/4; replicate=0.
  - Boot chunk k>=4*BANKS: byte dropped, dl_wait stays 0, state stays IDLE.
- dl_wr while busy: ignored; the host must honour dl_wait.
- FSM states:
  - IDLE: wait for a byte accept.
  - ARM: on ce_ref, wr=1.
  - WRITE: on the next ce_ref, complete the write.
- Write completion with replicate=1: wr_bank increments and the FSM returns to ARM. Replication starts at bank 0 and ends at bank BANKS-1.
- Final completion (last bank, or replicate=0):
  - wr=0, dl_wait=0, state IDLE.
  - If addr[ADDR_W-1]=1, set map[addr[21:14]].
  - If combo=1 and addr[13:0]==0x3FFF: combo=0 and page=0x1FF. This takes effect for the next byte.
- Each write therefore occupies 2 ce_ref slots per bank. wr_addr, wr_bank and wr_data are stable for as long as wr=1.
- dl falling while busy: the pending write completes normally. A new dl rising edge while busy updates page only after the FSM reaches IDLE (deferred).
- Map: map_hit <= map[map_addr] on every clk_sys edge. Bits are cleared only by reset_n, never by a new download.
- Simultaneous map set and query of the same page: map_hit shows the old value for that cycle and the new value the cycle after.

Test Plan:
- Boot file, index 0, byte 0xA5 at dl_addr 0x4000 -> wr_addr 0x400000, bank 0, 2 ce_ref slots, dl_wait drops; map[0x00] set.
- Boot file, dl_addr 0x1C000 (k=7), BANKS=2 -> wr_addr 0x7FC000 (page 0x1FF), bank 1; dl_addr 0x20000 (k=8) -> no wr, dl_wait stays 0.
- ext "0A", index 0x40, byte at 0x0005 -> writes at 0x428005 to banks 0 then 1 (4 ce_ref slots); map_hit=1 for map_addr 0x0A one cycle later.
- ext "Z0": 16 KB then 1 more byte -> first 16 KB written at page 0x000; byte 0x4000 written at page 0x1FF+1 wrapping to 0x100 (addr 0x400000).
- ext "Q7" -> ext_bad=1, byte 0 at 0x7B8000.
- Assert reset_n low during WRITE -> wr, dl_wait, busy and map_hit are 0 immediately; the map is empty after release.
